// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch sequencer with instruction buffer, redirect flush and halt detection
module fetch_sequencer #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] HALT_OP = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        fetch_pc_en,
  output logic        fetch_branch_en,
  output logic [7:0]  fetch_branch_addr,
  input  logic [15:0] fetch_instr,
  input  logic        redir_valid,
  input  logic [7:0]  redir_addr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [7:0]  dec_pc,
  output logic        halted,
  output logic [7:0]  fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t        state;
  logic [7:0]    shadow_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   instr_mem [DEPTH];
  logic [7:0]    pc_mem    [DEPTH];
  logic          push;
  logic          pop;

  // rst gates the handshakes combinationally so nothing leaks out during the reset cycle
  always_comb begin
    fetch_branch_en   = !rst && (state != IDLE) && redir_valid;
    fetch_branch_addr = redir_addr;
    dec_valid         = !rst && (count != '0) && !redir_valid;
    pop               = dec_valid && dec_ready;
    fetch_pc_en       = !rst && (state == RUN) && !redir_valid &&
                        ((count < CW'(DEPTH)) || pop);
    push              = fetch_pc_en;
    dec_instr         = instr_mem[rd_ptr];
    dec_pc            = pc_mem[rd_ptr];
  end

  assign halted = (state == HALTED);

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= fetch_instr;
      pc_mem[wr_ptr]    <= shadow_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow_pc   <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_count <= 8'h00;
    end else begin
      if (fetch_branch_en)  shadow_pc <= redir_addr;
      else if (fetch_pc_en) shadow_pc <= shadow_pc + 8'd2;

      if (fetch_branch_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end

      if (push && (fetch_count != 8'hFF)) fetch_count <= fetch_count + 8'd1;

      // leaving RUN on run==0 wins even when a redirect arrives in the same cycle
      case (state)
        IDLE:    if (run) state <= RUN;
        RUN: begin
          if (!run)                                  state <= IDLE;
          else if (push && (fetch_instr == HALT_OP)) state <= HALTED;
        end
        HALTED:  if (redir_valid) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        fetch_pc_en, fetch_branch_en;
  logic [7:0]  fetch_branch_addr;
  logic [15:0] fetch_instr;
  logic        redir_valid = 1'b0;
  logic [7:0]  redir_addr = 8'h00;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [15:0] dec_instr;
  logic [7:0]  dec_pc;
  logic        halted;
  logic [7:0]  fetch_count;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem_pc;
  logic       halt_en = 1'b0;
  logic [7:0] halt_pc = 8'h00;

  fetch_sequencer #(.DEPTH(4), .HALT_OP(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .run(run),
    .fetch_pc_en(fetch_pc_en), .fetch_branch_en(fetch_branch_en),
    .fetch_branch_addr(fetch_branch_addr), .fetch_instr(fetch_instr),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // fetch unit and instruction memory
  always_ff @(posedge clk) begin
    if (rst)                  mem_pc <= 8'h00;
    else if (fetch_branch_en) mem_pc <= fetch_branch_addr;
    else if (fetch_pc_en)     mem_pc <= mem_pc + 8'd2;
  end

  always_comb begin
    fetch_instr = {8'hA5, mem_pc};
    if (mem_pc < 8'd16) fetch_instr = 16'h1111 * ({8'd0, mem_pc} / 16'd2 + 16'd1);
    if (halt_en && (mem_pc == halt_pc)) fetch_instr = 16'hFFFF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; redir_valid = 1'b0; dec_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; redir_valid = 1'b1; redir_addr = 8'h55; dec_ready = 1'b1;
    tick(); tick();
    total++; if (fetch_pc_en !== 1'b0) $display("FAIL rst_pc_en got %0b want 0", fetch_pc_en); else passed++;
    total++; if (fetch_branch_en !== 1'b0) $display("FAIL rst_branch_en got %0b want 0", fetch_branch_en); else passed++;
    total++; if (dec_valid !== 1'b0) $display("FAIL rst_dec_valid got %0b want 0", dec_valid); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL rst_halted got %0b want 0", halted); else passed++;
    total++; if (fetch_count !== 8'h00) $display("FAIL rst_fetch_count got %0h want 0", fetch_count); else passed++;
    rst = 1'b0; run = 1'b0; redir_valid = 1'b0;
    tick();
    total++; if ({fetch_pc_en, dec_valid} !== 2'b00) $display("FAIL idle_outputs got %b want 00", {fetch_pc_en, dec_valid}); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    run = 1'b1; dec_ready = 1'b1;
    tick();
    total++; if (fetch_pc_en !== 1'b1) $display("FAIL stream_first_fetch got %0b want 1", fetch_pc_en); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({dec_valid, dec_pc, dec_instr, fetch_count} !== {1'b1, 8'(2 * i), 16'(16'h1111 * (i + 1)), 8'(i + 1)})
        $display("FAIL stream_%0d got v=%0b pc=%0h instr=%0h cnt=%0d want v=1 pc=%0h instr=%0h cnt=%0d",
                 i, dec_valid, dec_pc, dec_instr, fetch_count, 2 * i, 16'h1111 * (i + 1), i + 1);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    run = 1'b1; dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n += int'(fetch_pc_en);
    end
    total++; if (n != 4) $display("FAIL bp_push_count got %0d want 4", n); else passed++;
    total++; if ({fetch_pc_en, dec_pc, fetch_count} !== {1'b0, 8'h00, 8'd4})
      $display("FAIL bp_full got en=%0b pc=%0h cnt=%0d want en=0 pc=0 cnt=4", fetch_pc_en, dec_pc, fetch_count);
    else passed++;
    dec_ready = 1'b1; #1;
    total++; if (fetch_pc_en !== 1'b1) $display("FAIL bp_push_on_pop got %0b want 1", fetch_pc_en); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({dec_valid, dec_pc} !== {1'b1, 8'(2 * i)})
        $display("FAIL bp_drain_%0d got v=%0b pc=%0h want v=1 pc=%0h", i, dec_valid, dec_pc, 2 * i);
      else passed++;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    run = 1'b1; dec_ready = 1'b0;
    tick(); tick(); tick();
    redir_valid = 1'b1; redir_addr = 8'h40; #1;
    total++; if ({dec_valid, fetch_branch_en, fetch_pc_en, fetch_branch_addr} !== {3'b010, 8'h40})
      $display("FAIL redir_cycle got v=%0b br=%0b en=%0b addr=%0h want v=0 br=1 en=0 addr=40",
               dec_valid, fetch_branch_en, fetch_pc_en, fetch_branch_addr);
    else passed++;
    tick();
    redir_valid = 1'b0; #1;
    total++; if ({dec_valid, fetch_pc_en} !== 2'b01) $display("FAIL redir_flushed got v=%0b en=%0b want v=0 en=1", dec_valid, fetch_pc_en); else passed++;
    tick();
    total++; if ({dec_valid, dec_pc, dec_instr, fetch_count} !== {1'b1, 8'h40, 16'hA540, 8'd3})
      $display("FAIL redir_target got v=%0b pc=%0h instr=%0h cnt=%0d want v=1 pc=40 instr=a540 cnt=3",
               dec_valid, dec_pc, dec_instr, fetch_count);
    else passed++;
  endtask

  task automatic test_halt();
    logic [7:0] q[$];
    int npc = 0;
    halt_en = 1'b1; halt_pc = 8'h06;
    do_reset();
    run = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dec_valid) q.push_back(dec_pc);
      npc += int'(fetch_pc_en);
    end
    total++;
    if (q.size() != 4 || q[0] != 8'h00 || q[1] != 8'h02 || q[2] != 8'h04 || q[3] != 8'h06)
      $display("FAIL halt_delivered got size=%0d want 0,2,4,6", q.size());
    else passed++;
    total++; if (npc != 4) $display("FAIL halt_fetch_count got %0d want 4", npc); else passed++;
    total++; if ({halted, fetch_pc_en, dec_valid} !== 3'b100)
      $display("FAIL halt_state got h=%0b en=%0b v=%0b want h=1 en=0 v=0", halted, fetch_pc_en, dec_valid);
    else passed++;
    run = 1'b0; tick();
    total++; if (halted !== 1'b1) $display("FAIL halt_hold got %0b want 1", halted); else passed++;
    run = 1'b1; halt_en = 1'b0; redir_valid = 1'b1; redir_addr = 8'h20; #1;
    total++; if ({fetch_branch_en, fetch_pc_en} !== 2'b10) $display("FAIL halt_redir got br=%0b en=%0b want br=1 en=0", fetch_branch_en, fetch_pc_en); else passed++;
    tick();
    redir_valid = 1'b0; #1;
    total++; if ({halted, fetch_pc_en} !== 2'b01) $display("FAIL halt_resume got h=%0b en=%0b want h=0 en=1", halted, fetch_pc_en); else passed++;
    tick();
    total++; if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 8'h20, 16'hA520})
      $display("FAIL halt_target got v=%0b pc=%0h instr=%0h want v=1 pc=20 instr=a520", dec_valid, dec_pc, dec_instr);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFC; exp_pc[1] = 8'hFE; exp_pc[2] = 8'h00; exp_pc[3] = 8'h02;
    do_reset();
    run = 1'b1; dec_ready = 1'b1;
    tick();
    redir_valid = 1'b1; redir_addr = 8'hFC;
    tick();
    redir_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({dec_valid, dec_pc} !== {1'b1, exp_pc[i]})
        $display("FAIL wrap_%0d got v=%0b pc=%0h want v=1 pc=%0h", i, dec_valid, dec_pc, exp_pc[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1; dec_ready = 1'b0;
    repeat (6) tick();
    total++; if (dec_valid !== 1'b1) $display("FAIL mid_full got %0b want 1", dec_valid); else passed++;
    rst = 1'b1; #1;
    total++; if ({fetch_pc_en, dec_valid} !== 2'b00) $display("FAIL mid_during got en=%0b v=%0b want 00", fetch_pc_en, dec_valid); else passed++;
    tick();
    rst = 1'b0; run = 1'b0; #1;
    total++; if ({dec_valid, fetch_pc_en, fetch_branch_en, halted, fetch_count} !== {4'b0000, 8'h00})
      $display("FAIL mid_after got v=%0b en=%0b br=%0b h=%0b cnt=%0d want all 0",
               dec_valid, fetch_pc_en, fetch_branch_en, halted, fetch_count);
    else passed++;
    tick();
    total++; if ({dec_valid, fetch_pc_en} !== 2'b00) $display("FAIL mid_idle got v=%0b en=%0b want 00", dec_valid, fetch_pc_en); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, instruction-buffer entries (power of two, >=2).
REQ-002 Parameter: HALT_OP, 16'hFFFF, opcode that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; start/continue fetching from IDLE.
REQ-006 fetch_pc_en  output  1  to fetch unit: advance pc by 2 at next edge.
REQ-007 fetch_branch_en  output  1  to fetch unit: load pc from fetch_branch_addr at next edge.
REQ-008 fetch_branch_addr  output  8  branch target to fetch unit.
REQ-009 fetch_instr  input  16  instruction at fetch unit's current pc (combinational from memory).
REQ-010 redir_valid  input  1  one-cycle redirect request from execute.
REQ-011 redir_addr  input  8  redirect target pc.
REQ-012 dec_valid  output  1  buffer head valid toward decode.
REQ-013 dec_ready  input  1  decode accepts head this cycle.
REQ-014 dec_instr  output  16  head instruction.
REQ-015 dec_pc  output  8  pc of head instruction.
REQ-016 halted  output  1  high in state HALTED.
REQ-017 fetch_count  output  8  instructions pushed since reset, saturating at 255.

Function
REQ-018 The block SHALL implement states IDLE, RUN, HALTED; state is registered.
REQ-019 The block SHALL keep shadow_pc (8 bit) mirroring the fetch unit pc: +2 mod 256 on fetch_pc_en, load redir_addr on fetch_branch_en, hold otherwise.
REQ-020 fetch_branch_en SHALL equal redir_valid in RUN or HALTED; fetch_branch_addr SHALL equal redir_addr (combinational); in IDLE redir_valid is ignored.
REQ-021 fetch_pc_en SHALL be 1 only when state==RUN, !redir_valid, and (count<DEPTH or a pop occurs this cycle); both fetch outputs never high together.
REQ-022 Each fetch_pc_en cycle SHALL push {shadow_pc, fetch_instr} into the buffer at that edge.
REQ-023 dec_valid SHALL be (count!=0) && !redir_valid; dec_instr/dec_pc SHALL show the oldest entry; pop when dec_valid && dec_ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order; push into a full buffer occurs only with a same-cycle pop.
REQ-025 redir_valid SHALL flush the buffer (count=0) at that edge; no push and no pop occur that cycle; fetching resumes next cycle from redir_addr.
REQ-026 IDLE->RUN when run==1; RUN->IDLE when run==0 (buffer retained, no new fetch).
REQ-027 RUN->HALTED when the pushed fetch_instr equals HALT_OP; that entry IS pushed; no further fetch_pc_en in HALTED; buffer drains normally.
REQ-028 HALTED->RUN on redir_valid (flush and branch as REQ-025); otherwise HALTED persists regardless of run.
REQ-029 redir_valid in RUN takes priority over halt detection and run deassertion only for the flush/branch; the state transition from run==0 still applies.
REQ-030 fetch_count SHALL increment on each push, saturate at 255, and is not cleared by redirect.
REQ-031 Buffer pointers SHALL wrap modulo DEPTH; count width is clog2(DEPTH)+1.

Reset
REQ-032 On rst==1 at posedge: state=IDLE, shadow_pc=0, count=0, pointers=0, fetch_count=0.
REQ-033 During and after reset: fetch_pc_en=0, fetch_branch_en=0, dec_valid=0, halted=0; reset mid-operation discards all buffered entries.
REQ-034 rst SHALL override every other input in the same cycle.

Verification
REQ-035 Reset, run=1, dec_ready=1, memory words 0x1111,0x2222,... -> dec_pc 0,2,4,... in order, fetch_count counts up, one instruction per cycle after 1-cycle latency.
REQ-036 run=1, dec_ready=0 -> exactly 4 pushes (pc 0,2,4,6), fetch_pc_en drops, shadow_pc=8; dec_ready=1 then -> pops 0,2,4,6 then resumes at 8.
REQ-037 Buffer holding 2 entries, redir_valid=1, redir_addr=0x40 -> dec_valid=0 that cycle, fetch_branch_en=1, count=0 next cycle, next dec_pc=0x40.
REQ-038 HALT_OP at pc 0x06 -> entries 0,2,4,6 delivered, halted=1, no fetch_pc_en; redir to 0x20 -> halted=0, fetch resumes at 0x20.
REQ-039 redir_addr=0xFC, run=1 -> dec_pc sequence 0xFC,0xFE,0x00,0x02 (wrap-around).
REQ-040 rst=1 asserted with full buffer in RUN -> next cycle IDLE, dec_valid=0, fetch_count=0, no fetch output asserted.
